vrf_elem_sequencer: RTL and testbench

- Initiator side of the vector register file's per-lane read/write interface.
- Accepts one vector op (three source registers, one destination, vector length) on a valid/ready handshake.
- Walks the elements in lane-wide beats and drives per-lane read addresses.
- Writes back execution-unit results after a fixed execution latency, with lane write enables masked by vector length; pulses done when the last write has issued.

---
 rtl/vrf_elem_sequencer_if.sv | 49 ++++
 rtl/vrf_elem_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_vrf_elem_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_elem_sequencer_if.sv
// Purpose: bundles the op-request handshake, the register-file read/write ports
//          and the execution-unit result bus of the element sequencer.
// Ports:   master = sequencer view, slave = op source / register file / exe unit view.
interface vrf_elem_sequencer_if #(
    parameter int els_p   = 32,
    parameter int vlen_p  = 8,
    parameter int vdw_p   = 32,
    parameter int lanes_p = 4
);
    localparam int v_addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int local_addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int vl_width_lp         = $clog2(vlen_p + 1);

    // op request
    logic                                   v_i;
    logic                                   ready_o;
    logic [v_addr_width_lp-1:0]             vs0_i;
    logic [v_addr_width_lp-1:0]             vs1_i;
    logic [v_addr_width_lp-1:0]             vs2_i;
    logic [v_addr_width_lp-1:0]             vd_i;
    logic [vl_width_lp-1:0]                 vl_i;

    // register-file read side
    logic [v_addr_width_lp-1:0]             r_reg0_addr_o;
    logic [v_addr_width_lp-1:0]             r_reg1_addr_o;
    logic [v_addr_width_lp-1:0]             r_reg2_addr_o;
    logic [lanes_p*local_addr_width_lp-1:0] r_addr_o;
    logic [lanes_p-1:0]                     r_v_o;

    // execution-unit result and register-file write side
    logic [lanes_p*vdw_p-1:0]               exe_data_i;
    logic [v_addr_width_lp-1:0]             w_reg_addr_o;
    logic [lanes_p*local_addr_width_lp-1:0] w_addr_o;
    logic [lanes_p*vdw_p-1:0]               w_data_o;
    logic [lanes_p-1:0]                     w_en_o;
    logic                                   done_o;

    modport master (
        input  v_i, vs0_i, vs1_i, vs2_i, vd_i, vl_i, exe_data_i,
        output ready_o, r_reg0_addr_o, r_reg1_addr_o, r_reg2_addr_o, r_addr_o, r_v_o,
        output w_reg_addr_o, w_addr_o, w_data_o, w_en_o, done_o
    );

    modport slave (
        output v_i, vs0_i, vs1_i, vs2_i, vd_i, vl_i, exe_data_i,
        input  ready_o, r_reg0_addr_o, r_reg1_addr_o, r_reg2_addr_o, r_addr_o, r_v_o,
        input  w_reg_addr_o, w_addr_o, w_data_o, w_en_o, done_o
    );
endinterface

// File: rtl/vrf_elem_sequencer.sv
// Purpose: walks one vector op over the register file in lane-wide beats, then writes results back.
// Latency: reads at T+1..T+nb after accept at T, writes exe_lat_p cycles after each read, done with last write.
// Backpressure: ready_o only in IDLE; one op at a time, no overlap. Ports: clk_i, reset_i (async, high), io (master).
// Constraints: vlen_p must be a multiple of lanes_p and exe_lat_p must be >= 1.
module vrf_elem_sequencer #(
    parameter int els_p     = 32,
    parameter int vlen_p    = 8,
    parameter int vdw_p     = 32,
    parameter int lanes_p   = 4,
    parameter int exe_lat_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    vrf_elem_sequencer_if.master io
);
    localparam int v_addr_width_lp     = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int local_addr_width_lp = (vlen_p > 1) ? $clog2(vlen_p) : 1;
    localparam int vl_width_lp         = $clog2(vlen_p + 1);
    localparam int beats_lp            = vlen_p / lanes_p;
    localparam int beat_width_lp       = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int addr_bus_width_lp   = lanes_p * local_addr_width_lp;
    localparam int last_stage_lp       = exe_lat_p - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ZERO} state_e;

    // Element indices of every lane for a given beat.
    function automatic logic [addr_bus_width_lp-1:0] addr_f(input logic [beat_width_lp-1:0] b);
        logic [addr_bus_width_lp-1:0] a;
        a = '0;
        for (int l = 0; l < lanes_p; l++) begin
            a[l*local_addr_width_lp +: local_addr_width_lp] =
                local_addr_width_lp'(int'(b) * lanes_p + l);
        end
        return a;
    endfunction

    // Lanes whose element index falls inside the active vector length.
    function automatic logic [lanes_p-1:0] lane_mask_f(input logic [beat_width_lp-1:0] b,
                                                       input logic [vl_width_lp-1:0]   vl);
        logic [lanes_p-1:0] m;
        m = '0;
        for (int l = 0; l < lanes_p; l++) begin
            m[l] = ((int'(b) * lanes_p + l) < int'(vl));
        end
        return m;
    endfunction

    // Index of the final beat, ceil(vl/lanes_p)-1; only meaningful for vl >= 1.
    function automatic logic [beat_width_lp-1:0] last_beat_f(input logic [vl_width_lp-1:0] vl);
        int nb;
        nb = (int'(vl) + lanes_p - 1) / lanes_p;
        return beat_width_lp'(nb - 1);
    endfunction

    state_e                         state_q;
    logic [v_addr_width_lp-1:0]     vs0_q, vs1_q, vs2_q, vd_q;
    logic [vl_width_lp-1:0]         vl_q;
    logic [beat_width_lp-1:0]       beat_q;
    logic [beat_width_lp-1:0]       last_beat_q;
    logic [addr_bus_width_lp-1:0]   r_addr_q;
    logic [lanes_p-1:0]             r_v_q;
    logic                           zero_done_q;

    // Write pipe: one entry per read beat, shifted every cycle; the last stage is the write port.
    logic [exe_lat_p-1:0]                     pipe_v_q;
    logic [exe_lat_p-1:0]                     pipe_last_q;
    logic [exe_lat_p-1:0][beat_width_lp-1:0]  pipe_beat_q;
    logic [exe_lat_p-1:0][lanes_p-1:0]        pipe_mask_q;

    logic [vl_width_lp-1:0]         vl_clamped;
    logic [beat_width_lp-1:0]       beat_nxt;
    logic                           issuing;
    logic                           final_write;
    logic [lanes_p*vdw_p-1:0]       exe_data;

    always_comb begin
        vl_clamped = io.vl_i;
        if (io.vl_i > vl_width_lp'(vlen_p)) begin
            vl_clamped = vl_width_lp'(vlen_p);
        end
    end

    assign beat_nxt    = beat_q + beat_width_lp'(1);
    assign issuing     = (state_q == ISSUE);
    assign final_write = pipe_last_q[last_stage_lp];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            vs0_q       <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            vl_q        <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            r_addr_q    <= '0;
            r_v_q       <= '0;
            zero_done_q <= 1'b0;
            pipe_v_q    <= '0;
            pipe_last_q <= '0;
            pipe_beat_q <= '0;
            pipe_mask_q <= '0;
        end else begin
            // Stage 0 captures the beat currently presented on the read port.
            pipe_v_q[0]    <= issuing;
            pipe_last_q[0] <= issuing && (beat_q == last_beat_q);
            pipe_beat_q[0] <= beat_q;
            pipe_mask_q[0] <= issuing ? r_v_q : '0;
            for (int s = 1; s < exe_lat_p; s++) begin
                pipe_v_q[s]    <= pipe_v_q[s-1];
                pipe_last_q[s] <= pipe_last_q[s-1];
                pipe_beat_q[s] <= pipe_beat_q[s-1];
                pipe_mask_q[s] <= pipe_mask_q[s-1];
            end

            zero_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (io.v_i) begin
                        vs0_q  <= io.vs0_i;
                        vs1_q  <= io.vs1_i;
                        vs2_q  <= io.vs2_i;
                        vd_q   <= io.vd_i;
                        vl_q   <= vl_clamped;
                        beat_q <= '0;
                        if (vl_clamped == '0) begin
                            state_q     <= ZERO;
                            zero_done_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            last_beat_q <= last_beat_f(vl_clamped);
                            r_addr_q    <= addr_f('0);
                            r_v_q       <= lane_mask_f('0, vl_clamped);
                        end
                    end
                end
                ISSUE: begin
                    if (beat_q == last_beat_q) begin
                        state_q  <= DRAIN;
                        r_addr_q <= '0;
                        r_v_q    <= '0;
                    end else begin
                        beat_q   <= beat_nxt;
                        r_addr_q <= addr_f(beat_nxt);
                        r_v_q    <= lane_mask_f(beat_nxt, vl_q);
                    end
                end
                DRAIN: begin
                    // The final write is on the port this cycle; leave as it issues.
                    if (final_write) begin
                        state_q <= IDLE;
                        vs0_q   <= '0;
                        vs1_q   <= '0;
                        vs2_q   <= '0;
                        vd_q    <= '0;
                    end
                end
                ZERO: begin
                    state_q <= IDLE;
                    vs0_q   <= '0;
                    vs1_q   <= '0;
                    vs2_q   <= '0;
                    vd_q    <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign exe_data = io.exe_data_i;

    assign io.ready_o       = (state_q == IDLE);
    assign io.r_reg0_addr_o = vs0_q;
    assign io.r_reg1_addr_o = vs1_q;
    assign io.r_reg2_addr_o = vs2_q;
    assign io.r_addr_o      = r_addr_q;
    assign io.r_v_o         = r_v_q;
    assign io.w_reg_addr_o  = vd_q;
    assign io.w_addr_o      = pipe_v_q[last_stage_lp] ? addr_f(pipe_beat_q[last_stage_lp]) : '0;
    assign io.w_data_o      = exe_data;
    assign io.w_en_o        = pipe_mask_q[last_stage_lp];
    assign io.done_o        = final_write | zero_done_q;
endmodule

// File: tb/tb_vrf_elem_sequencer.sv
// Purpose: scoreboard bench for vrf_elem_sequencer at default parameters.
// Latency: expected read/write/done events carry their required cycle numbers.
// Backpressure: ready_o is checked every cycle against the busy window of the current op.
module tb_vrf_elem_sequencer;
    localparam int LANES = 4;
    localparam int VLEN  = 8;
    localparam int LAT   = 2;
    localparam int LAW   = 3;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [3:0]  mask;
        logic [4:0]  r0, r1, r2;
    } rd_t;

    typedef struct {
        int          cyc;
        logic [11:0] addr;
        logic [3:0]  mask;
        logic [4:0]  rd;
    } wr_t;

    logic         clk_i;
    logic         reset_i;
    logic [127:0] exe_data;
    int           cyc;
    int           n_cmp;
    int           n_bad;
    bit           mon_en;
    int           busy_from;
    int           busy_to;
    rd_t          rd_q[$];
    wr_t          wr_q[$];
    int           done_q[$];

    vrf_elem_sequencer_if #(.els_p(32), .vlen_p(8), .vdw_p(32), .lanes_p(4)) dut_if ();

    vrf_elem_sequencer #(
        .els_p(32), .vlen_p(8), .vdw_p(32), .lanes_p(4), .exe_lat_p(2)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .io     (dut_if)
    );

    assign dut_if.exe_data_i = exe_data;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        exe_data = {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [11:0] lane_addr(input int b);
        logic [11:0] a;
        a = '0;
        for (int l = 0; l < LANES; l++) a[l*LAW +: LAW] = 3'(b * LANES + l);
        return a;
    endfunction

    // Monitor: every negedge compare DUT activity against the scoreboard.
    always @(negedge clk_i) begin
        if (mon_en) begin
            check_val("ready", dut_if.ready_o, (cyc >= busy_from && cyc <= busy_to) ? 1'b0 : 1'b1);
            if (dut_if.r_v_o != 4'b0) begin
                if (rd_q.size() == 0) begin
                    check_val("rd_unexpected", dut_if.r_v_o, 4'b0);
                end else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    check_val("rd_cycle", cyc, e.cyc);
                    check_val("r_addr", dut_if.r_addr_o, e.addr);
                    check_val("r_v", dut_if.r_v_o, e.mask);
                    check_val("r_reg0", dut_if.r_reg0_addr_o, e.r0);
                    check_val("r_reg1", dut_if.r_reg1_addr_o, e.r1);
                    check_val("r_reg2", dut_if.r_reg2_addr_o, e.r2);
                end
            end
            if (dut_if.w_en_o != 4'b0) begin
                if (wr_q.size() == 0) begin
                    check_val("wr_unexpected", dut_if.w_en_o, 4'b0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check_val("wr_cycle", cyc, w.cyc);
                    check_val("w_addr", dut_if.w_addr_o, w.addr);
                    check_val("w_en", dut_if.w_en_o, w.mask);
                    check_val("w_reg", dut_if.w_reg_addr_o, w.rd);
                    check_val("w_data", dut_if.w_data_o, exe_data);
                end
            end
            if (dut_if.done_o) begin
                if (done_q.size() == 0) begin
                    check_val("done_unexpected", dut_if.done_o, 1'b0);
                end else begin
                    int dc;
                    dc = done_q.pop_front();
                    check_val("done_cycle", cyc, dc);
                end
            end
        end
    end

    task automatic send_op(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic [3:0] vl, input bit hold,
                           output int t_acc);
        int guard;
        int vc;
        int nb;
        @(negedge clk_i);
        dut_if.vs0_i = s0;
        dut_if.vs1_i = s1;
        dut_if.vs2_i = s2;
        dut_if.vd_i  = d;
        dut_if.vl_i  = vl;
        dut_if.v_i   = 1'b1;
        guard = 0;
        while (dut_if.ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) check_val("accept_timeout", dut_if.ready_o, 1'b1);
        t_acc = cyc;
        vc = (int'(vl) > VLEN) ? VLEN : int'(vl);
        nb = (vc + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            rd_t r;
            wr_t w;
            logic [3:0] m;
            for (int l = 0; l < LANES; l++) m[l] = (b * LANES + l) < vc;
            r.cyc = t_acc + 1 + b; r.addr = lane_addr(b); r.mask = m;
            r.r0 = s0; r.r1 = s1; r.r2 = s2;
            w.cyc = t_acc + 1 + b + LAT; w.addr = lane_addr(b); w.mask = m; w.rd = d;
            rd_q.push_back(r);
            wr_q.push_back(w);
        end
        busy_from = t_acc + 1;
        busy_to   = (vc == 0) ? t_acc + 1 : t_acc + nb + LAT;
        done_q.push_back(busy_to);
        if (!hold) begin
            @(posedge clk_i);
            #1 dut_if.v_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((rd_q.size() + wr_q.size() + done_q.size() != 0 || dut_if.ready_o !== 1'b1)
               && guard < 60) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 60) check_val("idle_timeout", 32'(rd_q.size() + wr_q.size() + done_q.size()), 0);
        @(negedge clk_i);
    endtask

    initial begin
        int t1;
        int t2;
        cyc = 0; n_cmp = 0; n_bad = 0; mon_en = 0;
        busy_from = 1; busy_to = 0;
        reset_i = 1'b1;
        dut_if.v_i = 1'b0;
        dut_if.vs0_i = '0; dut_if.vs1_i = '0; dut_if.vs2_i = '0;
        dut_if.vd_i = '0; dut_if.vl_i = '0;

        repeat (3) @(negedge clk_i);
        check_val("rst_ready", dut_if.ready_o, 1'b1);
        check_val("rst_r_v", dut_if.r_v_o, 4'b0);
        check_val("rst_r_addr", dut_if.r_addr_o, 12'b0);
        check_val("rst_r_reg0", dut_if.r_reg0_addr_o, 5'b0);
        check_val("rst_w_en", dut_if.w_en_o, 4'b0);
        check_val("rst_w_addr", dut_if.w_addr_o, 12'b0);
        check_val("rst_w_reg", dut_if.w_reg_addr_o, 5'b0);
        check_val("rst_done", dut_if.done_o, 1'b0);
        @(posedge clk_i);
        #2 reset_i = 1'b0;
        mon_en = 1;

        // Full-length op, partial last beat, single partial beat, clamped length, zero length.
        send_op(5'd3, 5'd7, 5'd9, 5'd5, 4'd8, 0, t1);  wait_idle();
        send_op(5'd1, 5'd2, 5'd4, 5'd6, 4'd6, 0, t1);  wait_idle();
        send_op(5'd10, 5'd11, 5'd12, 5'd13, 4'd3, 0, t1); wait_idle();
        send_op(5'd31, 5'd0, 5'd17, 5'd30, 4'd12, 0, t1); wait_idle();
        send_op(5'd8, 5'd8, 5'd8, 5'd8, 4'd0, 0, t1); wait_idle();

        // v_i held high across two ops: second accepted only after the first completes.
        send_op(5'd2, 5'd3, 5'd4, 5'd5, 4'd8, 1, t1);
        send_op(5'd20, 5'd21, 5'd22, 5'd23, 4'd8, 0, t2);
        check_val("b2b_accept_gap", 32'(t2 - t1), 32'(VLEN / LANES + LAT + 1));
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            send_op(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    4'($urandom_range(0, 15)), 0, t1);
            wait_idle();
        end

        // Reset in the middle of the second read beat abandons the op.
        send_op(5'd3, 5'd7, 5'd9, 5'd5, 4'd8, 0, t1);
        @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check_val("midrst_r_v", dut_if.r_v_o, 4'b0);
        check_val("midrst_w_en", dut_if.w_en_o, 4'b0);
        check_val("midrst_done", dut_if.done_o, 1'b0);
        check_val("midrst_ready", dut_if.ready_o, 1'b1);
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        busy_from = 1; busy_to = 0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #2 reset_i = 1'b0;
        repeat (8) @(negedge clk_i);

        send_op(5'd14, 5'd15, 5'd16, 5'd18, 4'd5, 0, t1); wait_idle();

        check_val("left_rd", 32'(rd_q.size()), 0);
        check_val("left_wr", 32'(wr_q.size()), 0);
        check_val("left_done", 32'(done_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
